// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
//   WORD_WIDTH  : operand/result width
//   DCODE_WIDTH : width of the decoded_instr opcode code
//   INSTR_*     : M-class decoded_instr codes
//   md_decode() : maps an opcode code to its operand-signedness/result-select flags
package multdiv_seq_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned DCODE_WIDTH = 7;
  localparam int unsigned ACC_WIDTH   = 2 * WORD_WIDTH;
  localparam int unsigned MD_ITERS    = WORD_WIDTH;
  localparam int unsigned CNT_WIDTH   = $clog2(MD_ITERS);

  typedef logic [DCODE_WIDTH-1:0] dcode_t;

  localparam dcode_t INSTR_MUL    = 7'h30;
  localparam dcode_t INSTR_MULH   = 7'h31;
  localparam dcode_t INSTR_MULHSU = 7'h32;
  localparam dcode_t INSTR_MULHU  = 7'h33;
  localparam dcode_t INSTR_DIV    = 7'h34;
  localparam dcode_t INSTR_DIVU   = 7'h35;
  localparam dcode_t INSTR_REM    = 7'h36;
  localparam dcode_t INSTR_REMU   = 7'h37;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_SIGN = 2'd2,
    MD_DONE = 2'd3
  } multdiv_state_t;

  // Per-op control flags resolved at accept time
  typedef struct packed {
    logic is_m;     // recognised M-class op
    logic is_div;   // divide/remainder loop instead of multiply
    logic sgn1;     // rs1 treated as signed
    logic sgn2;     // rs2 treated as signed
    logic sel_hi;   // return product[63:32]
    logic sel_rem;  // return remainder instead of quotient
  } md_dec_t;

  function automatic md_dec_t md_decode(input dcode_t op);
    md_dec_t d;
    d = '0;
    case (op)
      INSTR_MUL:    begin d.is_m = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      INSTR_MULH:   begin d.is_m = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; d.sel_hi = 1'b1; end
      INSTR_MULHSU: begin d.is_m = 1'b1; d.sgn1 = 1'b1; d.sel_hi = 1'b1; end
      INSTR_MULHU:  begin d.is_m = 1'b1; d.sel_hi = 1'b1; end
      INSTR_DIV:    begin d.is_m = 1'b1; d.is_div = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      INSTR_DIVU:   begin d.is_m = 1'b1; d.is_div = 1'b1; end
      INSTR_REM:    begin d.is_m = 1'b1; d.is_div = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1;
                          d.sel_rem = 1'b1; end
      INSTR_REMU:   begin d.is_m = 1'b1; d.is_div = 1'b1; d.sel_rem = 1'b1; end
      default:      d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multdiv_seq_step.sv
// One iteration of the unsigned multiply/divide loop (purely combinational).
//   i_is_div : 1 = restoring shift-subtract, 0 = shift-add
//   i_acc    : mul {partial_hi, multiplier_remaining}; div {remainder, dividend/quotient}
//   i_opnd   : multiplicand (mul) or divisor (div)
//   o_acc    : accumulator after this iteration
module multdiv_seq_step
  import multdiv_seq_pkg::*;
(
  input  logic                  i_is_div,
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [WORD_WIDTH-1:0] i_opnd,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  logic [WORD_WIDTH:0] w_sum;
  logic [WORD_WIDTH:0] w_rem_sh;
  logic [WORD_WIDTH:0] w_diff;

  always_comb begin
    // mul: add multiplicand into the high half when the current multiplier bit is set
    w_sum    = {1'b0, i_acc[ACC_WIDTH-1:WORD_WIDTH]}
             + (i_acc[0] ? {1'b0, i_opnd} : (WORD_WIDTH+1)'(0));
    // div: remainder shifted left by one, pulling in the next dividend bit
    w_rem_sh = i_acc[ACC_WIDTH-1:WORD_WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    o_acc    = '0;
    if (i_is_div) begin
      // borrow in bit WORD_WIDTH means the trial subtract went negative: restore
      if (!w_diff[WORD_WIDTH]) begin
        o_acc = {w_diff[WORD_WIDTH-1:0], i_acc[WORD_WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_rem_sh[WORD_WIDTH-1:0], i_acc[WORD_WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WORD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative RV32M sequencer: 1 bit/cycle shift-add multiply or restoring divide
// on operand magnitudes, with a final sign fix-up stage.
//   clk_i, rst_i            : clock, async active-high reset
//   op_valid_i/op_ready_o   : op handshake (ready only in IDLE)
//   op_i, rs1_i, rs2_i      : decoded M-class code and operands
//   kill_i                  : flush, returns to IDLE next edge
//   res_valid_o/res_ready_i : result handshake
//   result_o                : 32-bit result, stable while res_valid_o=1
//   busy_o                  : stall request (state != IDLE)
module multdiv_seq
  import multdiv_seq_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  input  logic [DCODE_WIDTH-1:0] op_i,
  input  logic [WORD_WIDTH-1:0]  rs1_i,
  input  logic [WORD_WIDTH-1:0]  rs2_i,
  input  logic                   kill_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WORD_WIDTH-1:0]  result_o,
  output logic                   busy_o
);

  multdiv_state_t        r_state;
  multdiv_state_t        w_next_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [WORD_WIDTH-1:0] r_opnd;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_is_div;
  logic                  r_neg_res;
  logic                  r_sel_hi;
  logic                  r_sel_rem;
  logic [WORD_WIDTH-1:0] r_result;

  md_dec_t               w_dec;
  logic                  w_accept;
  logic                  w_s1_neg;
  logic                  w_s2_neg;
  logic [WORD_WIDTH-1:0] w_abs1;
  logic [WORD_WIDTH-1:0] w_abs2;
  logic                  w_neg_res;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_fast;
  logic [WORD_WIDTH-1:0] w_fast_result;
  logic [ACC_WIDTH-1:0]  w_step_acc;
  logic [ACC_WIDTH-1:0]  w_prod;
  logic [WORD_WIDTH-1:0] w_div_sel;
  logic [WORD_WIDTH-1:0] w_sign_result;
  logic                  w_op_ready;
  logic                  w_res_valid;
  logic                  w_busy;

  // Accept-time decode: magnitudes, result sign and special-case divides
  always_comb begin
    w_dec      = md_decode(op_i);
    w_accept   = op_valid_i & (r_state == MD_IDLE) & ~kill_i & w_dec.is_m;
    w_s1_neg   = w_dec.sgn1 & rs1_i[WORD_WIDTH-1];
    w_s2_neg   = w_dec.sgn2 & rs2_i[WORD_WIDTH-1];
    w_abs1     = w_s1_neg ? (~rs1_i) + WORD_WIDTH'(1) : rs1_i;
    w_abs2     = w_s2_neg ? (~rs2_i) + WORD_WIDTH'(1) : rs2_i;
    // remainder takes the dividend's sign; quotient/product the xor of both
    w_neg_res  = w_dec.sel_rem ? w_s1_neg : (w_s1_neg ^ w_s2_neg);
    w_div_zero = (rs2_i == '0);
    w_div_ovf  = w_dec.sgn1 & (rs1_i == {1'b1, {(WORD_WIDTH-1){1'b0}}}) & (rs2_i == '1);
    w_fast     = w_dec.is_div & (w_div_zero | w_div_ovf);
    if (w_div_zero) begin
      w_fast_result = w_dec.sel_rem ? rs1_i : '1;
    end else begin
      // signed overflow: quotient is the dividend itself, remainder zero
      w_fast_result = w_dec.sel_rem ? '0 : rs1_i;
    end
  end

  multdiv_seq_step u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign fix-up and result selection
  always_comb begin
    w_prod        = r_neg_res ? (~r_acc) + ACC_WIDTH'(1) : r_acc;
    w_div_sel     = r_sel_rem ? r_acc[ACC_WIDTH-1:WORD_WIDTH] : r_acc[WORD_WIDTH-1:0];
    if (r_neg_res) begin
      w_div_sel = (~w_div_sel) + WORD_WIDTH'(1);
    end
    if (r_is_div) begin
      w_sign_result = w_div_sel;
    end else if (r_sel_hi) begin
      w_sign_result = w_prod[ACC_WIDTH-1:WORD_WIDTH];
    end else begin
      w_sign_result = w_prod[WORD_WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; kill overrides everything
  always_comb begin
    w_next_state = r_state;
    if (kill_i) begin
      w_next_state = MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: if (w_accept) w_next_state = w_fast ? MD_DONE : MD_CALC;
        MD_CALC: if (r_cnt == CNT_WIDTH'(MD_ITERS - 1)) w_next_state = MD_SIGN;
        MD_SIGN: w_next_state = MD_DONE;
        MD_DONE: if (res_ready_i) w_next_state = MD_IDLE;
        default: w_next_state = MD_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    w_op_ready  = (r_state == MD_IDLE);
    w_res_valid = (r_state == MD_DONE);
    w_busy      = (r_state != MD_IDLE);
  end

  assign op_ready_o  = w_op_ready;
  assign res_valid_o = w_res_valid;
  assign busy_o      = w_busy;
  assign result_o    = r_result;

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_sel_hi  <= 1'b0;
      r_sel_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            // mul: acc={0,multiplier}, opnd=multiplicand; div: acc={0,dividend}, opnd=divisor
            r_acc     <= {WORD_WIDTH'(0), (w_dec.is_div ? w_abs1 : w_abs2)};
            r_opnd    <= w_dec.is_div ? w_abs2 : w_abs1;
            r_cnt     <= '0;
            r_is_div  <= w_dec.is_div;
            r_neg_res <= w_neg_res;
            r_sel_hi  <= w_dec.sel_hi;
            r_sel_rem <= w_dec.sel_rem;
            if (w_fast) begin
              r_result <= w_fast_result;
            end
          end
        end
        MD_CALC: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        MD_SIGN: begin
          if (!kill_i) begin
            r_result <= w_sign_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
